branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit.
// Keeps an in-order FIFO of predicted branches produced by fetch. Each
// resolution from execute is compared against the oldest record. The unit
// then trains the predictor one cycle later and, on a mispredict, issues a
// one-cycle redirect, flushes every in-flight record and stalls for one
// recovery cycle.
module branch_resolve_unit #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            pred_valid,
    input  logic [31:0]                     pred_pc,
    input  logic                            pred_taken,
    input  logic [31:0]                     pred_target,
    output logic                            pred_ready,
    input  logic                            res_valid,
    input  logic                            res_taken,
    input  logic [31:0]                     res_target,
    output logic                            res_ready,
    output logic                            upd_en,
    output logic [31:0]                     upd_pc,
    output logic                            upd_taken,
    output logic                            redirect_valid,
    output logic [31:0]                     redirect_pc,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [CNT_WIDTH-1:0]            stat_branches,
    output logic [CNT_WIDTH-1:0]            stat_mispredicts
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Sequential fall-through address of a branch (wraps modulo 2^32).
    function automatic logic [31:0] fall_through(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    state_t               state_q, state_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [31:0]          mem_pc_q     [FIFO_DEPTH];
    logic                 mem_taken_q  [FIFO_DEPTH];
    logic [31:0]          mem_target_q [FIFO_DEPTH];

    logic                 upd_en_q, upd_en_d;
    logic [31:0]          upd_pc_q, upd_pc_d;
    logic                 upd_taken_q, upd_taken_d;
    logic                 redir_valid_q, redir_valid_d;
    logic [31:0]          redir_pc_q, redir_pc_d;
    logic [CNT_WIDTH-1:0] stat_br_q, stat_br_d;
    logic [CNT_WIDTH-1:0] stat_mis_q, stat_mis_d;

    // ---------------------------------------------------------------
    // Handshake and compare logic
    // ---------------------------------------------------------------
    logic                 pred_ready_s;
    logic                 res_ready_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 mispredict_s;
    logic                 mem_we_s;
    logic [31:0]          head_pc_s;
    logic                 head_taken_s;
    logic [31:0]          head_target_s;

    // Ready flags depend only on registered state, so a same-cycle pop never
    // frees room for a push and a same-cycle push never feeds a resolve.
    always_comb begin
        pred_ready_s = (state_q == ST_RUN) && (count_q < CNT_W'(FIFO_DEPTH));
        res_ready_s  = (state_q == ST_RUN) && (count_q != {CNT_W{1'b0}});
        push_s       = pred_valid && pred_ready_s;
        pop_s        = res_valid && res_ready_s;
    end

    // Oldest record and the mispredict decision against it.
    always_comb begin
        head_pc_s     = mem_pc_q[rd_ptr_q];
        head_taken_s  = mem_taken_q[rd_ptr_q];
        head_target_s = mem_target_q[rd_ptr_q];
        if (pop_s) begin
            mispredict_s = (head_taken_s != res_taken) ||
                           (res_taken && head_taken_s && (head_target_s != res_target));
        end else begin
            mispredict_s = 1'b0;
        end
        // A push landing on the flush edge is dropped with the rest.
        mem_we_s = push_s && !mispredict_s;
    end

    // Next-state computation for FSM, pointers, occupancy, outputs, counters.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        upd_en_d      = 1'b0;
        upd_pc_d      = upd_pc_q;
        upd_taken_d   = upd_taken_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        stat_br_d     = stat_br_q;
        stat_mis_d    = stat_mis_q;

        // Training and redirect information for the cycle after a resolve.
        if (pop_s) begin
            upd_en_d    = 1'b1;
            upd_pc_d    = head_pc_s;
            upd_taken_d = res_taken;
            stat_br_d   = sat_inc(stat_br_q);
            if (mispredict_s) begin
                redir_valid_d = 1'b1;
                redir_pc_d    = res_taken ? res_target : fall_through(head_pc_s);
                stat_mis_d    = sat_inc(stat_mis_q);
            end else begin
                redir_valid_d = 1'b0;
            end
        end else begin
            upd_en_d = 1'b0;
        end

        // Pointer and occupancy bookkeeping; a flush overrides everything.
        if (mispredict_s) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // RUN/RECOVER sequencing: recovery always lasts exactly one cycle.
        case (state_q)
            ST_RUN: begin
                if (mispredict_s) begin
                    state_d = ST_RECOVER;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RECOVER: state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    // Control, output and statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
            upd_en_q      <= 1'b0;
            upd_pc_q      <= 32'd0;
            upd_taken_q   <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 32'd0;
            stat_br_q     <= {CNT_WIDTH{1'b0}};
            stat_mis_q    <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            upd_en_q      <= upd_en_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            stat_br_q     <= stat_br_d;
            stat_mis_q    <= stat_mis_d;
        end
    end

    // Record storage; cleared on reset so stale entries never surface as X.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_pc_q[i]     <= 32'd0;
                mem_taken_q[i]  <= 1'b0;
                mem_target_q[i] <= 32'd0;
            end
        end else if (mem_we_s) begin
            mem_pc_q[wr_ptr_q]     <= pred_pc;
            mem_taken_q[wr_ptr_q]  <= pred_taken;
            mem_target_q[wr_ptr_q] <= pred_target;
        end else begin
            mem_pc_q[wr_ptr_q]     <= mem_pc_q[wr_ptr_q];
            mem_taken_q[wr_ptr_q]  <= mem_taken_q[wr_ptr_q];
            mem_target_q[wr_ptr_q] <= mem_target_q[wr_ptr_q];
        end
    end

    // ---------------------------------------------------------------
    // Output mapping
    // ---------------------------------------------------------------
    assign pred_ready       = pred_ready_s;
    assign res_ready        = res_ready_s;
    assign upd_en           = upd_en_q;
    assign upd_pc           = upd_pc_q;
    assign upd_taken        = upd_taken_q;
    assign redirect_valid   = redir_valid_q;
    assign redirect_pc      = redir_pc_q;
    assign fifo_count       = count_q;
    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;
    localparam int CW    = 6;
    localparam int FCW   = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic            clk;
    logic            reset;
    logic            pred_valid;
    logic [31:0]     pred_pc;
    logic            pred_taken;
    logic [31:0]     pred_target;
    logic            pred_ready;
    logic            res_valid;
    logic            res_taken;
    logic [31:0]     res_target;
    logic            res_ready;
    logic            upd_en;
    logic [31:0]     upd_pc;
    logic            upd_taken;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic [FCW-1:0]  fifo_count;
    logic [CW-1:0]   stat_branches;
    logic [CW-1:0]   stat_mispredicts;

    branch_resolve_unit #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .res_ready(res_ready),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fifo_count(fifo_count), .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } rec_t;

    rec_t        mq[$];
    bit          live = 1'b0;
    bit          m_rec;
    bit          m_upd_en;
    logic [31:0] m_upd_pc;
    bit          m_upd_taken;
    bit          m_rv;
    logic [31:0] m_rpc;
    int          m_br;
    int          m_mis;
    bit          a_push, a_res, mis;
    rec_t        h;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_rec = 0; m_upd_en = 0; m_upd_pc = 32'd0; m_upd_taken = 0;
            m_rv = 0; m_rpc = 32'd0; m_br = 0; m_mis = 0;
            live = 1'b1;
        end else if (live) begin
            a_push   = pred_valid && !m_rec && (mq.size() < DEPTH);
            a_res    = res_valid && !m_rec && (mq.size() > 0);
            m_upd_en = 0;
            m_rv     = 0;
            mis      = 0;
            if (a_res) begin
                h = mq.pop_front();
                mis = (h.taken != res_taken) || (res_taken && (h.target != res_target));
                m_upd_en    = 1;
                m_upd_pc    = h.pc;
                m_upd_taken = res_taken;
                if (m_br < CMAX) m_br++;
                if (mis) begin
                    m_rv  = 1;
                    m_rpc = res_taken ? res_target : h.pc + 32'd4;
                    if (m_mis < CMAX) m_mis++;
                end
            end
            if (mis) begin
                mq.delete();
                m_rec = 1;
            end else begin
                m_rec = 0;
                if (a_push) mq.push_back('{pc: pred_pc, taken: pred_taken, target: pred_target});
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (live) begin
            chk("pred_ready", pred_ready, !m_rec && (mq.size() < DEPTH));
            chk("res_ready", res_ready, !m_rec && (mq.size() > 0));
            chk("fifo_count", fifo_count, mq.size());
            chk("upd_en", upd_en, m_upd_en);
            chk("upd_pc", upd_pc, m_upd_pc);
            chk("upd_taken", upd_taken, m_upd_taken);
            chk("redirect_valid", redirect_valid, m_rv);
            chk("redirect_pc", redirect_pc, m_rpc);
            chk("stat_branches", stat_branches, m_br);
            chk("stat_mispredicts", stat_mispredicts, m_mis);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit rst, input bit pv, input logic [31:0] ppc, input bit pt,
                        input logic [31:0] ptg, input bit rv, input bit rt, input logic [31:0] rtg);
        reset = rst; pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
        res_valid = rv; res_taken = rt; res_target = rtg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 32'd0, 0, 32'd0, 0, 0, 32'd0);
    endtask

    task automatic push(input logic [31:0] pc, input bit t, input logic [31:0] tg);
        step(0, 1, pc, t, tg, 0, 0, 32'd0);
    endtask

    task automatic resolve(input bit t, input logic [31:0] tg);
        step(0, 0, 32'd0, 0, 32'd0, 1, t, tg);
    endtask

    initial begin
        reset = 1'b1; pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
        res_valid = 0; res_taken = 0; res_target = 0;
        step(1, 0, 32'd0, 0, 32'd0, 0, 0, 32'd0);
        step(1, 0, 32'd0, 0, 32'd0, 0, 0, 32'd0);
        idle();
        chk("rst_count", fifo_count, 0);
        chk("rst_upd_en", upd_en, 0);
        chk("rst_pred_ready", pred_ready, 1);
        chk("rst_stat", stat_branches, 0);

        // Correctly predicted not-taken branch.
        push(32'h100, 0, 32'd0);
        resolve(0, 32'd0);
        chk("d1_upd_en", upd_en, 1);
        chk("d1_upd_pc", upd_pc, 32'h100);
        chk("d1_upd_taken", upd_taken, 0);
        chk("d1_redirect", redirect_valid, 0);
        chk("d1_stat", stat_branches, 1);

        // Direction mispredict flushes the queue.
        push(32'h200, 0, 32'd0);
        push(32'h204, 0, 32'd0);
        resolve(1, 32'h400);
        chk("d2_redirect", redirect_valid, 1);
        chk("d2_redirect_pc", redirect_pc, 32'h400);
        chk("d2_count", fifo_count, 0);
        chk("d2_mis", stat_mispredicts, 1);
        chk("d2_pred_ready_rec", pred_ready, 0);
        idle();
        chk("d2_pred_ready_run", pred_ready, 1);
        chk("d2_redirect_off", redirect_valid, 0);

        // Target mispredict, then fall-through wrap.
        push(32'h300, 1, 32'h500);
        resolve(1, 32'h600);
        chk("d3_redirect_pc", redirect_pc, 32'h600);
        chk("d3_upd_taken", upd_taken, 1);
        idle();
        push(32'hFFFF_FFFC, 1, 32'h10);
        resolve(0, 32'd0);
        chk("d3_wrap_pc", redirect_pc, 32'h0000_0000);
        chk("d3_wrap_v", redirect_valid, 1);
        idle();

        // Full queue, simultaneous push+resolve, order preservation.
        for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i * 4), 0, 32'd0);
        chk("d4_full_count", fifo_count, DEPTH);
        chk("d4_full_ready", pred_ready, 0);
        resolve(0, 32'd0);
        chk("d4_pop_pc", upd_pc, 32'h1000);
        chk("d4_count3", fifo_count, 3);
        step(0, 1, 32'h2000, 0, 32'd0, 1, 0, 32'd0);
        chk("d4_same_count", fifo_count, 3);
        chk("d4_same_pc", upd_pc, 32'h1004);
        resolve(0, 32'd0);
        chk("d4_ord0", upd_pc, 32'h1008);
        resolve(0, 32'd0);
        chk("d4_ord1", upd_pc, 32'h100C);
        resolve(0, 32'd0);
        chk("d4_ord2", upd_pc, 32'h2000);
        chk("d4_empty", fifo_count, 0);

        // Resolve on empty, reset mid-operation.
        chk("d5_res_ready", res_ready, 0);
        resolve(0, 32'd0);
        chk("d5_no_upd", upd_en, 0);
        push(32'h3000, 0, 32'd0);
        push(32'h3004, 0, 32'd0);
        step(1, 1, 32'h3008, 0, 32'd0, 1, 1, 32'h44);
        chk("d5_rst_count", fifo_count, 0);
        chk("d5_rst_upd", upd_en, 0);
        chk("d5_rst_redir", redirect_valid, 0);
        chk("d5_rst_stat", stat_branches, 0);

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            logic        rs, pv, pt, rv, rt;
            logic [31:0] ppc, ptg, rtg;
            rs  = ($urandom_range(0, 699) == 0);
            pv  = ($urandom_range(0, 9) < 6);
            ppc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            pt  = $urandom_range(0, 1);
            ptg = ($urandom_range(0, 1) == 1) ? 32'h40 : 32'h80;
            rv  = ($urandom_range(0, 1) == 1);
            if ((mq.size() > 0) && ($urandom_range(0, 3) != 0)) begin
                rt  = mq[0].taken;
                rtg = mq[0].target;
            end else begin
                rt  = $urandom_range(0, 1);
                rtg = ($urandom_range(0, 1) == 1) ? 32'h40 : 32'h80;
            end
            step(rs, pv, ppc, pt, ptg, rv, rt, rtg);
        end
        idle();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
